// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  // abs_mag works on a MAX_W-bit container; callers cast in and out.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Magnitude of a width-bit value held zero-extended in MAX_W bits.
  // The low width bits of the negation are the width-bit two's-complement
  // negation, so |MIN_INT| = 2^(width-1) comes out correctly.
  function automatic logic [MAX_W-1:0] abs_mag(input logic [MAX_W-1:0] value,
                                               input logic signed_op,
                                               input int unsigned width);
    logic [MAX_W-1:0] sign_mask;
    sign_mask = MAX_W'(1) << (width - 1);
    if (signed_op && ((value & sign_mask) != '0)) return -value;
    return value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {R,Q}, trial-subtract D.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] trial;
  logic             ge;

  // One guard bit above R keeps the trial-subtract sign unambiguous.
  assign r_sh   = {r, q[WIDTH-1]};
  assign trial  = r_sh - {2'b00, d};
  assign ge     = ~trial[WIDTH+1];
  assign r_next = ge ? trial[WIDTH:0] : r_sh[WIDTH:0];
  assign q_next = {q[WIDTH-2:0], ge};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider, signed/unsigned, start/busy/done.
//   state | meaning
//   IDLE  | waiting for start; results held
//   CALC  | WIDTH shift/subtract iterations on the magnitudes
//   FIX   | apply signs / divide-by-zero override, pulse done
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   r_acc, r_nxt;
  logic [WIDTH-1:0] q_acc, q_nxt;
  logic [WIDTH-1:0] d_acc;
  logic [WIDTH-1:0] dvd_raw;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             q_neg, r_neg;

  assign dvd_mag = WIDTH'(abs_mag(MAX_W'(dividend), signed_op, WIDTH));
  assign dvs_mag = WIDTH'(abs_mag(MAX_W'(divisor), signed_op, WIDTH));

  div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_acc),
    .q      (q_acc),
    .d      (d_acc),
    .r_next (r_nxt),
    .q_next (q_nxt)
  );

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt         <= '0;
      r_acc       <= '0;
      q_acc       <= '0;
      d_acc       <= '0;
      dvd_raw     <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          r_acc   <= '0;
          q_acc   <= dvd_mag;
          d_acc   <= dvs_mag;
          dvd_raw <= dividend;
          q_neg   <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg   <= signed_op & dividend[WIDTH-1];
          cnt     <= CNT_W'(WIDTH);
        end
        CALC: begin
          r_acc <= r_nxt;
          q_acc <= q_nxt;
          cnt   <= cnt - CNT_W'(1);
        end
        FIX: begin
          done <= 1'b1;
          // Divide by zero still runs the iterations so latency never varies.
          if (d_acc == '0) begin
            quotient    <= '1;
            remainder   <= dvd_raw;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_neg ? -q_acc : q_acc;
            remainder   <= r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: transaction-level reference model plus directed cases.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int asserts = 0;
  int failures = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  logic [W:0]   st_r, st_rn;
  logic [W-1:0] st_q, st_d, st_qn;

  div_step #(.WIDTH(W)) u_step_chk (
    .r      (st_r),
    .q      (st_q),
    .d      (st_d),
    .r_next (st_rn),
    .q_next (st_qn)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference division from plain integer arithmetic.
  function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dbz);
    longint sa, sb;
    if (b == '0) begin
      q = '1; r = a; dbz = 1'b1;
    end else begin
      dbz = 1'b0;
      if (s) begin
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      q = W'(sa / sb);
      r = W'(sa % sb);
    end
  endfunction

  // Transaction model: an accepted request finishes W+1 edges after capture.
  logic         pend = 1'b0;
  int           rem_edges = 0;
  logic         m_done = 1'b0, m_dbz = 1'b0, p_dbz;
  logic [W-1:0] m_q = '0, m_r = '0, p_q, p_r;

  always @(posedge clk) begin
    if (clr) begin
      pend = 1'b0; rem_edges = 0; m_done = 1'b0;
      m_q = '0; m_r = '0; m_dbz = 1'b0;
    end else begin
      m_done = 1'b0;
      if (pend) begin
        rem_edges--;
        if (rem_edges == 0) begin
          pend = 1'b0; m_done = 1'b1;
          m_q = p_q; m_r = p_r; m_dbz = p_dbz;
        end
      end else if (start) begin
        ref_div(signed_op, dividend, divisor, p_q, p_r, p_dbz);
        pend = 1'b1;
        rem_edges = W + 1;
      end
    end
  end

  always @(negedge clk) begin
    asserts++;
    if (busy !== pend || done !== m_done || quotient !== m_q ||
        remainder !== m_r || div_by_zero !== m_dbz) begin
      failures++;
      $display("FAIL model_cmp t=%0t: busy/done/dbz %b%b%b exp %b%b%b q %h exp %h r %h exp %h",
               $time, busy, done, div_by_zero, pend, m_done, m_dbz,
               quotient, m_q, remainder, m_r);
    end
  end

  task automatic wait_done(output int edges, output int busy_cyc);
    edges = 1;
    busy_cyc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) return;
      @(posedge clk);
      edges++;
    end
    asserts++;
    failures++;
    $display("FAIL done_timeout: got no done after %0d edges, expected done at edge %0d", edges, W + 2);
  endtask

  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int edges, output int busy_cyc);
    @(negedge clk);
    start = 1'b1; signed_op = s; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    signed_op = 1'($urandom_range(0, 1));
    wait_done(edges, busy_cyc);
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3, 4:    return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int edges, bcyc;
    logic seen_done;
    longint rsh;

    for (int i = 0; i < 16; i++) begin
      st_d = W'($urandom) | 32'h1;
      st_r = {1'b0, W'($urandom) % st_d};
      st_q = W'($urandom);
      #1;
      rsh = 2 * longint'(st_r) + longint'(st_q[W-1]);
      if (rsh >= longint'(st_d)) begin
        check("step_r", 64'(st_rn), 64'(rsh - longint'(st_d)));
        check("step_q", 64'(st_qn), 64'({st_q[W-2:0], 1'b1}));
      end else begin
        check("step_r", 64'(st_rn), 64'(rsh));
        check("step_q", 64'(st_qn), 64'({st_q[W-2:0], 1'b0}));
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_q", 64'(quotient), 64'd0);
    check("rst_r", 64'(remainder), 64'd0);
    clr = 1'b0;

    run_op(1'b0, 32'd100, 32'd7, edges, bcyc);
    check("u100_7_edges", 64'(edges), 64'd34);
    check("u100_7_busy", 64'(bcyc), 64'd33);
    check("u100_7_q", 64'(quotient), 64'd14);
    check("u100_7_r", 64'(remainder), 64'd2);
    check("u100_7_dbz", 64'(div_by_zero), 64'd0);

    run_op(1'b1, -32'sd100, 32'd7, edges, bcyc);
    check("sm100_7_q", 64'(quotient), 64'hFFFF_FFF2);
    check("sm100_7_r", 64'(remainder), 64'hFFFF_FFFE);

    run_op(1'b1, 32'd100, -32'sd7, edges, bcyc);
    check("s100_m7_q", 64'(quotient), 64'hFFFF_FFF2);
    check("s100_m7_r", 64'(remainder), 64'd2);

    run_op(1'b0, 32'h1234_5678, 32'd0, edges, bcyc);
    check("dbz_edges", 64'(edges), 64'd34);
    check("dbz_q", 64'(quotient), 64'hFFFF_FFFF);
    check("dbz_r", 64'(remainder), 64'h1234_5678);
    check("dbz_flag", 64'(div_by_zero), 64'd1);

    run_op(1'b0, 32'd9, 32'd3, edges, bcyc);
    check("after_dbz_flag", 64'(div_by_zero), 64'd0);
    check("after_dbz_q", 64'(quotient), 64'd3);

    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, edges, bcyc);
    check("ovf_q", 64'(quotient), 64'h8000_0000);
    check("ovf_r", 64'(remainder), 64'd0);
    check("ovf_dbz", 64'(div_by_zero), 64'd0);

    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, edges, bcyc);
    check("umax_q", 64'(quotient), 64'hFFFF_FFFF);
    check("umax_r", 64'(remainder), 64'd0);

    // 50/5, ignored 1/1 at edge 10, then 81/9 issued in the done cycle.
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 32'd1; divisor = 32'd1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(edges, bcyc);
    check("b2b_first_q", 64'(quotient), 64'd10);
    check("b2b_first_r", 64'(remainder), 64'd0);
    start = 1'b1; dividend = 32'd81; divisor = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("b2b_done_drop", 64'(done), 64'd0);
    check("b2b_busy_rise", 64'(busy), 64'd1);
    wait_done(edges, bcyc);
    check("b2b_second_edges", 64'(edges), 64'd33);
    check("b2b_second_q", 64'(quotient), 64'd9);
    check("b2b_second_r", 64'(remainder), 64'd0);

    // Abort with clr at edge 15.
    @(negedge clk);
    start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_q", 64'(quotient), 64'd0);
    check("abort_r", 64'(remainder), 64'd0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    run_op(1'b0, 32'd81, 32'd9, edges, bcyc);
    check("post_abort_edges", 64'(edges), 64'd34);
    check("post_abort_q", 64'(quotient), 64'd9);

    // Random traffic, including starts while busy and occasional clr.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      signed_op = 1'($urandom_range(0, 1));
      dividend = pick_val();
      divisor = pick_val();
      clr = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    clr = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle radix-2 restoring divider. It is the inverse counterpart of the team's combinational Booth multiplier.
- Takes a WIDTH-bit dividend and divisor and produces a quotient and remainder. These feed the CPU's LO and HI registers for the DIV instruction.
- Handshake is start/busy/done. Operands are captured on start.
- Supports signed (truncate toward zero) and unsigned modes.

Parameters:
- WIDTH, 32, operand/quotient/remainder width (must be >= 4)
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- clr  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only when busy=0
- signed_op  in  1  1 = two's-complement operands, 0 = unsigned; captured with start
- dividend  in  WIDTH  numerator; captured with start
- divisor  in  WIDTH  denominator; captured with start
- busy  out  1  high from the edge after start is accepted until the edge that asserts done
- done  out  1  single-cycle pulse; results are valid in this cycle
- quotient  out  WIDTH  result to LO; held until the next done
- remainder  out  WIDTH  result to HI; held until the next done
- div_by_zero  out  1  updated with done; 1 when the captured divisor == 0

Behaviour:
- Reset (clr=1 at an edge):
  - state -> IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
  - clr overrides start and aborts any in-flight operation. No done is produced for an aborted operation.
- States: IDLE, CALC, FIX.
- IDLE:
  - On start=1, capture the operands, then move to CALC with busy=1.
  - If signed_op=1, store the magnitudes |dividend| and |divisor|. Also store q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - If signed_op=0, use the operands raw with q_neg = r_neg = 0.
  - Magnitudes are computed as WIDTH-bit unsigned values, so |MIN_INT| = 2^(WIDTH-1) is representable.
  - Partial remainder R (WIDTH+1 bits) <- 0, Q <- dividend magnitude, counter <- WIDTH.
- CALC, one iteration per edge:
  - {R,Q} shift left by 1.
  - T = R - D (WIDTH+1 bits).
  - If T >= 0 (its MSB is 0): R <- T and Q[0] <- 1. Otherwise R is unchanged and Q[0] <- 0.
  - counter decrements each edge. On the edge where counter reaches 0, move to FIX.
- FIX, one edge:
  - quotient <- q_neg ? -Q : Q; remainder <- r_neg ? -R[WIDTH-1:0] : R[WIDTH-1:0].
  - done <- 1 and busy <- 0, then return to IDLE.
- Latency is fixed. done is high in the cycle following edge number WIDTH+2, counting the start-sampling edge as edge 1. That is 34 edges for WIDTH=32.
- Divide by zero:
  - The iterations run anyway, to keep latency uniform.
  - FIX forces quotient = all ones, remainder = captured dividend (raw, not the magnitude), div_by_zero=1.
- Overflow: signed MIN_INT / -1 yields quotient = MIN_INT (wrapped) and remainder = 0, with div_by_zero=0. No trap is raised.
- Operand timing: start while busy=1 is ignored. Input changes after capture have no effect.
- Back-to-back operation: start asserted in the same cycle that done is high is accepted, because the state is IDLE. done deasserts on that edge and busy rises.
- Result hold: quotient, remainder and div_by_zero change only in FIX or on clr.

Decomposition:
- Package div_pkg holds:
  - the state typedef: enum IDLE, CALC, FIX;
  - the localparam for the default WIDTH;
  - a function abs_mag(value, signed_op) returning an unsigned magnitude.
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: R, Q, D. Outputs: R', Q'.
  - Instantiated once inside CALC and verified standalone.

Test Plan:
- Unsigned 100 / 7 (signed_op=0) -> done after 34 edges, quotient=14, remainder=2, div_by_zero=0; busy high for exactly 33 cycles.
- Signed -100 / 7 -> quotient=-14 (0xFFFFFFF2), remainder=-2 (0xFFFFFFFE). Signed 100 / -7 -> quotient=-14, remainder=2.
- Divisor 0 with dividend 0x12345678 -> same 34-edge latency, quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1. A following 9/3 clears div_by_zero and gives quotient=3.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
- Start 50/5, pulse start again at edge 10 with 1/1, then assert start in the done cycle with 81/9:
  - The edge-10 request is ignored and the first result is quotient=10, remainder=0.
  - The done-cycle request is accepted and the second result is quotient=9, remainder=0.
- Assert clr at edge 15 of an operation -> next cycle busy=0, done=0, quotient=0, remainder=0. No done pulse follows; a fresh start afterward completes normally.
